// File: rtl/pbl_entrada_ctrl.sv
// ---------------------------------------------------------------------------
// pbl_entrada_ctrl
//
// Input-conditioning stage in front of the profile/permission decoder.
// The raw switches and push-buttons are synchronized, the buttons are
// debounced into single-cycle press pulses, and a two-state capture FSM
// presents a stable switch snapshot with a function selector.
//
// Parameters
//   DEB_CYCLES  consecutive stable cycles before a button level change is
//               accepted (>= 1). Board builds override it (e.g. 50000).
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous, active-low reset
//   CH[7:0]  in   raw switches (IE01 code/req in [7:4], IE02 code/req in [3:0])
//   B[3:0]   in   raw push-buttons, active-low
//                 B[3] next function, B[2] confirm, B[1] clear, B[0] reserved
//   CH_REG   out  switch snapshot taken at confirm
//   FUN_SEL  out  selected function 0..3
//   VALID    out  high while CH_REG/FUN_SEL form a confirmed pair
//   NEW      out  one-cycle pulse on each capture
// ---------------------------------------------------------------------------
module pbl_entrada_ctrl #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] CH,
  input  logic [3:0] B,
  output logic [7:0] CH_REG,
  output logic [1:0] FUN_SEL,
  output logic       VALID,
  output logic       NEW
);

  localparam int unsigned   CW       = $clog2(DEB_CYCLES + 1);
  // Counter value at which one more mismatching sample completes the window.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  // -------------------------------------------------------------------------
  // Two-flop synchronizers. Buttons reset to the released level so a button
  // held through reset is debounced afresh after release.
  // -------------------------------------------------------------------------
  logic [7:0] r_ch_s1;
  logic [7:0] r_ch_s2;
  logic [3:0] r_b_s1;
  logic [3:0] r_b_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_s1 <= '0;
      r_ch_s2 <= '0;
      r_b_s1  <= '1;
      r_b_s2  <= '1;
    end else begin
      r_ch_s1 <= CH;
      r_ch_s2 <= r_ch_s1;
      r_b_s1  <= B;
      r_b_s2  <= r_b_s1;
    end
  end

  // -------------------------------------------------------------------------
  // Debouncers, one per button. The counter tracks how many consecutive
  // samples have disagreed with the accepted level; any agreeing sample
  // clears it, so a bounce shorter than DEB_CYCLES is never accepted.
  // A press pulse is registered on the same edge that accepts a 1->0 change.
  // -------------------------------------------------------------------------
  logic [3:0]    r_stable;
  logic [3:0]    r_press;
  logic [CW-1:0] r_cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '1;
      r_press  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_press[i] <= 1'b0;
        if (r_b_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_stable[i] <= r_b_s2[i];
          r_cnt[i]    <= '0;
          // Accepting a change away from 1 means the button went down.
          r_press[i]  <= r_stable[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic w_nxt;
  logic w_cfm;
  logic w_clr;
  logic w_unused_rsvd;

  assign w_nxt         = r_press[3];
  assign w_cfm         = r_press[2];
  assign w_clr         = r_press[1];
  // Reserved button is debounced but deliberately drives nothing.
  assign w_unused_rsvd = r_press[0];

  // -------------------------------------------------------------------------
  // Capture FSM with registered outputs. Priority: clear > confirm > next;
  // only the highest-priority pulse in a cycle takes effect.
  // -------------------------------------------------------------------------
  state_t     r_state;
  logic [7:0] r_ch_reg;
  logic [1:0] r_fun_sel;
  logic       r_valid;
  logic       r_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ch_reg  <= '0;
      r_fun_sel <= '0;
      r_valid   <= 1'b0;
      r_new     <= 1'b0;
    end else begin
      r_new <= 1'b0;
      if (w_clr) begin
        // Snapshot and function are kept; only the pair is invalidated.
        r_state <= S_IDLE;
        r_valid <= 1'b0;
      end else if (w_cfm) begin
        r_ch_reg <= r_ch_s2;
        r_state  <= S_HOLD;
        r_valid  <= 1'b1;
        r_new    <= 1'b1;
      end else if (w_nxt) begin
        r_fun_sel <= r_fun_sel + 2'd1;
        // A changed function must never be presented with an old snapshot.
        if (r_state == S_HOLD) begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign CH_REG  = r_ch_reg;
  assign FUN_SEL = r_fun_sel;
  assign VALID   = r_valid;
  assign NEW     = r_new;

endmodule

// File: tb/tb_pbl_entrada_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pbl_entrada_ctrl
//
// Bench for pbl_entrada_ctrl with DEB_CYCLES = 4. A behavioural model tracks
// the raw input history: the debouncer at edge n sees the raw button value
// applied at edge n-2, accepts a new level once the last DEB samples all
// differ from the accepted one, and the FSM acts one edge after the press.
// ---------------------------------------------------------------------------
module tb_pbl_entrada_ctrl;

  localparam int unsigned DEB = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] ch;
  logic [3:0] b;
  logic [7:0] ch_reg;
  logic [1:0] fun_sel;
  logic       valid;
  logic       dut_new;

  pbl_entrada_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .CH      (ch),
    .B       (b),
    .CH_REG  (ch_reg),
    .FUN_SEL (fun_sel),
    .VALID   (valid),
    .NEW     (dut_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] hb[$];    // raw buttons per edge since reset
  logic [7:0] hc[$];    // raw switches per edge since reset
  logic [3:0] sh[$];    // samples seen by the debouncers
  logic [3:0] m_stable;
  logic [3:0] m_pend;
  logic [7:0] m_ch;
  logic [1:0] m_fun;
  logic       m_valid;
  logic       m_new;

  task automatic model_reset();
    hb.delete(); hc.delete(); sh.delete();
    m_stable = 4'hF; m_pend = 4'h0;
    m_ch = 8'h00; m_fun = 2'd0; m_valid = 1'b0; m_new = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] s;
    logic [7:0] c;
    logic [3:0] pr;
    bit         all;
    s = (hb.size() >= 2) ? hb[hb.size()-2] : 4'hF;
    c = (hc.size() >= 2) ? hc[hc.size()-2] : 8'h00;
    m_new = 1'b0;
    if (m_pend[1]) m_valid = 1'b0;
    else if (m_pend[2]) begin m_ch = c; m_valid = 1'b1; m_new = 1'b1; end
    else if (m_pend[3]) begin m_fun = 2'((m_fun + 1) % 4); m_valid = 1'b0; end
    sh.push_back(s);
    if (sh.size() > DEB + 2) void'(sh.pop_front());
    pr = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (sh.size() >= DEB) begin
        all = 1;
        for (int j = 0; j < int'(DEB); j++)
          if (sh[sh.size()-1-j][i] == m_stable[i]) all = 0;
        if (all) begin
          pr[i] = m_stable[i];
          m_stable[i] = ~m_stable[i];
        end
      end
    end
    m_pend = pr;
    hb.push_back(b);
    hc.push_back(ch);
    if (hb.size() > 4) begin void'(hb.pop_front()); void'(hc.pop_front()); end
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare all outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    #1;
    if (rst_n)
      chk("model", {20'd0, ch_reg, fun_sel, valid, dut_new}, {20'd0, m_ch, m_fun, m_valid, m_new});
  endtask

  task automatic press(input logic [3:0] mask, input int unsigned hold);
    b = 4'hF & ~mask;
    repeat (hold) tick();
    b = 4'hF;
    repeat (8) tick();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0] b;
    logic [7:0] ch;
    logic [7:0] n;
    logic [7:0] e_ch;
    logic [1:0] e_fun;
    logic       e_valid;
    logic       e_new;
  } vec_t;

  vec_t vt [12];
  int   cnt;

  initial begin
    vt[0]  = '{b:4'hF, ch:8'hA2, n:8'd4,  e_ch:8'h00, e_fun:2'd0, e_valid:1'b0, e_new:1'b0};
    vt[1]  = '{b:4'hB, ch:8'hA2, n:8'd6,  e_ch:8'h00, e_fun:2'd0, e_valid:1'b0, e_new:1'b0};
    vt[2]  = '{b:4'hB, ch:8'hA2, n:8'd1,  e_ch:8'hA2, e_fun:2'd0, e_valid:1'b1, e_new:1'b1};
    vt[3]  = '{b:4'hB, ch:8'h00, n:8'd1,  e_ch:8'hA2, e_fun:2'd0, e_valid:1'b1, e_new:1'b0};
    vt[4]  = '{b:4'hF, ch:8'h00, n:8'd10, e_ch:8'hA2, e_fun:2'd0, e_valid:1'b1, e_new:1'b0};
    vt[5]  = '{b:4'h7, ch:8'h00, n:8'd7,  e_ch:8'hA2, e_fun:2'd1, e_valid:1'b0, e_new:1'b0};
    vt[6]  = '{b:4'hF, ch:8'h00, n:8'd8,  e_ch:8'hA2, e_fun:2'd1, e_valid:1'b0, e_new:1'b0};
    vt[7]  = '{b:4'h9, ch:8'h00, n:8'd7,  e_ch:8'hA2, e_fun:2'd1, e_valid:1'b0, e_new:1'b0};
    vt[8]  = '{b:4'hF, ch:8'h00, n:8'd8,  e_ch:8'hA2, e_fun:2'd1, e_valid:1'b0, e_new:1'b0};
    vt[9]  = '{b:4'h3, ch:8'h5C, n:8'd7,  e_ch:8'h5C, e_fun:2'd1, e_valid:1'b1, e_new:1'b1};
    vt[10] = '{b:4'hF, ch:8'h5C, n:8'd8,  e_ch:8'h5C, e_fun:2'd1, e_valid:1'b1, e_new:1'b0};
    vt[11] = '{b:4'h7, ch:8'h5C, n:8'd7,  e_ch:8'h5C, e_fun:2'd2, e_valid:1'b0, e_new:1'b0};

    // Reset with all buttons held and switches high.
    rst_n = 1'b0; b = 4'h0; ch = 8'hFF;
    model_reset();
    repeat (3) tick();
    chk("rst_ch_reg", {24'd0, ch_reg}, 32'h00);
    chk("rst_fun_sel", {30'd0, fun_sel}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_new", {31'd0, dut_new}, 32'd0);
    rst_n = 1'b1;
    model_reset();
    repeat (12) tick();
    chk("held_all_valid", {31'd0, valid}, 32'd0);
    chk("held_all_fun", {30'd0, fun_sel}, 32'd0);
    b = 4'hF;
    repeat (8) tick();

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      b = vt[i].b; ch = vt[i].ch;
      repeat (int'(vt[i].n)) tick();
      chk($sformatf("vec%0d", i), {20'd0, ch_reg, fun_sel, valid, dut_new},
          {20'd0, vt[i].e_ch, vt[i].e_fun, vt[i].e_valid, vt[i].e_new});
    end

    // Next wraps 3 -> 0 and drops VALID; confirm restores it.
    b = 4'hF;
    do_reset();
    repeat (3) press(4'b1000, 7);
    press(4'b0100, 7);
    chk("pre_wrap_fun", {30'd0, fun_sel}, 32'd3);
    chk("pre_wrap_valid", {31'd0, valid}, 32'd1);
    press(4'b1000, 7);
    chk("wrap_fun", {30'd0, fun_sel}, 32'd0);
    chk("wrap_valid", {31'd0, valid}, 32'd0);
    press(4'b0100, 7);
    chk("reconfirm_valid", {31'd0, valid}, 32'd1);

    // Bounce shorter than DEB is rejected; a clean 6-cycle press is taken.
    b = 4'h7; repeat (3) tick();
    b = 4'hF; repeat (1) tick();
    b = 4'h7; repeat (3) tick();
    b = 4'hF; repeat (8) tick();
    chk("bounce_fun", {30'd0, fun_sel}, 32'd0);
    chk("bounce_valid", {31'd0, valid}, 32'd1);
    press(4'b1000, 6);
    chk("clean_fun", {30'd0, fun_sel}, 32'd1);
    chk("clean_valid", {31'd0, valid}, 32'd0);

    // Confirm held for 100 cycles yields a single NEW pulse.
    cnt = 0;
    b = 4'hB;
    repeat (100) begin
      tick();
      if (dut_new) cnt++;
    end
    b = 4'hF;
    repeat (8) tick();
    chk("held_new_pulses", cnt, 32'd1);
    chk("held_valid", {31'd0, valid}, 32'd1);

    // Asynchronous reset in HOLD during a next-button debounce.
    b = 4'h7;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {21'd0, ch_reg, fun_sel, valid}, 32'd0);
    chk("async_rst_new", {31'd0, dut_new}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    model_reset();
    repeat (6) tick();
    chk("post_rst_no_pulse", {30'd0, fun_sel}, 32'd0);
    tick();
    chk("post_rst_debounced", {30'd0, fun_sel}, 32'd1);
    b = 4'hF;
    repeat (8) tick();

    // Random segments against the model.
    for (int s = 0; s < 500; s++) begin
      b  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      ch = 8'($urandom);
      repeat ($urandom_range(1, 8)) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
